// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen constants, probe indices and signed coordinate type
package game_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int NUM_PROBES = 5;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [2:0] {
    BOTTOM = 3'd0,
    TOP    = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    BODY   = 3'd4
  } probe_e;

  // Zero-extend an unsigned screen coordinate so negative window origins compare correctly
  function automatic coord_t to_coord(input logic [9:0] v);
    return coord_t'({1'b0, v});
  endfunction

endpackage

// File: rtl/probe_window_cmp.sv
// rtl/probe_window_cmp.sv - signed half-open rectangle membership test
module probe_window_cmp
  import game_pkg::*;
#(
  parameter int w = 32,
  parameter int h = 2
) (
  input  coord_t x,
  input  coord_t y,
  input  coord_t x0,
  input  coord_t y0,
  output logic   hit
);

  coord_t x1;
  coord_t y1;

  assign x1  = x0 + coord_t'(w);
  assign y1  = y0 + coord_t'(h);
  assign hit = (x >= x0) && (x < x1) && (y >= y0) && (y < y1);

endmodule

// File: rtl/wall_probe_collider.sv
// rtl/wall_probe_collider.sv - per-frame wall contact flags for one player sprite
module wall_probe_collider
  import game_pkg::*;
#(
  parameter int PLAYER_W = 32,
  parameter int PLAYER_H = 32,
  parameter int PROBE    = 2,
  parameter int CNT_W    = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             Blank_n,
  input  logic             is_Wall,
  input  logic             Frame_tick,
  input  logic [9:0]       PosX,
  input  logic [9:0]       PosY,
  output logic             Hit_bottom,
  output logic             Hit_top,
  output logic             Hit_left,
  output logic             Hit_right,
  output logic             Overlap,
  output logic [CNT_W-1:0] Ground_cnt,
  output logic             Flags_valid
);

  logic [9:0]            s1_x_q, s1_y_q;
  logic                  s1_blank_q, s1_wall_q;
  logic [9:0]            sx_q, sy_q, sx_d, sy_d;
  logic [NUM_PROBES-1:0] acc_hit_q, acc_hit_d;
  logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;
  logic [NUM_PROBES-1:0] hit_q, hit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  armed_q, armed_d;

  coord_t                s1_xc, s1_yc, sx_c, sy_c;
  coord_t                bot_y0, top_y0, left_x0, right_x0;
  logic [NUM_PROBES-1:0] win_hit;
  logic [NUM_PROBES-1:0] contrib;
  logic [NUM_PROBES-1:0] hit_sum;
  logic [CNT_W-1:0]      cnt_sum;

  assign s1_xc    = to_coord(s1_x_q);
  assign s1_yc    = to_coord(s1_y_q);
  assign sx_c     = to_coord(sx_q);
  assign sy_c     = to_coord(sy_q);
  assign bot_y0   = sy_c + coord_t'(PLAYER_H);
  assign top_y0   = sy_c - coord_t'(PROBE);
  assign left_x0  = sx_c - coord_t'(PROBE);
  assign right_x0 = sx_c + coord_t'(PLAYER_W);

  probe_window_cmp #(.w(PLAYER_W), .h(PROBE)) u_bottom (
    .x(s1_xc), .y(s1_yc), .x0(sx_c), .y0(bot_y0), .hit(win_hit[BOTTOM])
  );
  probe_window_cmp #(.w(PLAYER_W), .h(PROBE)) u_top (
    .x(s1_xc), .y(s1_yc), .x0(sx_c), .y0(top_y0), .hit(win_hit[TOP])
  );
  probe_window_cmp #(.w(PROBE), .h(PLAYER_H)) u_left (
    .x(s1_xc), .y(s1_yc), .x0(left_x0), .y0(sy_c), .hit(win_hit[LEFT])
  );
  probe_window_cmp #(.w(PROBE), .h(PLAYER_H)) u_right (
    .x(s1_xc), .y(s1_yc), .x0(right_x0), .y0(sy_c), .hit(win_hit[RIGHT])
  );
  probe_window_cmp #(.w(PLAYER_W), .h(PLAYER_H)) u_body (
    .x(s1_xc), .y(s1_yc), .x0(sx_c), .y0(sy_c), .hit(win_hit[BODY])
  );

  assign contrib = win_hit & {NUM_PROBES{s1_blank_q & s1_wall_q}};
  assign hit_sum = acc_hit_q | contrib;
  assign cnt_sum = (contrib[BOTTOM] && (acc_cnt_q != {CNT_W{1'b1}})) ?
                   acc_cnt_q + CNT_W'(1) : acc_cnt_q;

  // The pixel sitting in stage 1 on the tick cycle still belongs to the closing frame
  always_comb begin
    sx_d      = sx_q;
    sy_d      = sy_q;
    acc_hit_d = hit_sum;
    acc_cnt_d = cnt_sum;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    armed_d   = armed_q;
    if (Frame_tick) begin
      sx_d      = PosX;
      sy_d      = PosY;
      acc_hit_d = '0;
      acc_cnt_d = '0;
      armed_d   = 1'b1;
      valid_d   = armed_q;
      if (armed_q) begin
        hit_d = hit_sum;
        cnt_d = cnt_sum;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_blank_q <= 1'b0;
      s1_wall_q  <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      acc_hit_q  <= '0;
      acc_cnt_q  <= '0;
      hit_q      <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      s1_x_q     <= DrawX;
      s1_y_q     <= DrawY;
      s1_blank_q <= Blank_n & ~Frame_tick;
      s1_wall_q  <= is_Wall;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      acc_hit_q  <= acc_hit_d;
      acc_cnt_q  <= acc_cnt_d;
      hit_q      <= hit_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
    end
  end

  assign Hit_bottom  = hit_q[BOTTOM];
  assign Hit_top     = hit_q[TOP];
  assign Hit_left    = hit_q[LEFT];
  assign Hit_right   = hit_q[RIGHT];
  assign Overlap     = hit_q[BODY];
  assign Ground_cnt  = cnt_q;
  assign Flags_valid = valid_q;

endmodule

// File: tb/tb_wall_probe_collider.sv
// tb/tb_wall_probe_collider.sv - directed bench for wall_probe_collider
module tb_wall_probe_collider;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic       blank_n = 1'b0, frame_tick = 1'b0;
  logic       is_wall;

  logic       hb8, ht8, hl8, hr8, ov8, fv8;
  logic [7:0] gc8;
  logic       hb4, ht4, hl4, hr4, ov4, fv4;
  logic [3:0] gc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic map_wall(input logic [9:0] x, input logic [9:0] y);
    return (x < 25) || (int'(x) >= H_ACTIVE - 25) || (y < 25) || (int'(y) >= V_ACTIVE - 25) ||
           (((y == 391) || (y == 392)) && (x < 215));
  endfunction

  assign is_wall = map_wall(draw_x, draw_y);

  wall_probe_collider dut (
    .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .Blank_n(blank_n),
    .is_Wall(is_wall), .Frame_tick(frame_tick), .PosX(pos_x), .PosY(pos_y),
    .Hit_bottom(hb8), .Hit_top(ht8), .Hit_left(hl8), .Hit_right(hr8), .Overlap(ov8),
    .Ground_cnt(gc8), .Flags_valid(fv8)
  );

  wall_probe_collider #(.CNT_W(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .Blank_n(blank_n),
    .is_Wall(is_wall), .Frame_tick(frame_tick), .PosX(pos_x), .PosY(pos_y),
    .Hit_bottom(hb4), .Hit_top(ht4), .Hit_left(hl4), .Hit_right(hr4), .Overlap(ov4),
    .Ground_cnt(gc4), .Flags_valid(fv4)
  );

  typedef struct {
    int         px;
    int         py;
    logic [4:0] hits;  // {body, right, left, top, bottom}
    int         cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic b, input logic t);
    draw_x     = 10'(x);
    draw_y     = 10'(y);
    blank_n    = b;
    frame_tick = t;
    @(posedge clk);
    #1;
    blank_n    = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    drive(0, 0, 1'b0, 1'b1);
  endtask

  task automatic scan(input int sx, input int sy);
    for (int dy = -4; dy < 32 + 2 + 4; dy++)
      for (int dx = -4; dx < 32 + 2 + 4; dx++)
        drive((sx + dx) & 1023, (sy + dy) & 1023, 1'b1, 1'b0);
    // Blanked wall pixels inside the feet strip must not count
    for (int i = 0; i < 4; i++) drive(sx, sy + 32, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [4:0] hits, input int cnt);
    check({tag, ".valid"},  int'(fv8), 1);
    check({tag, ".valid4"}, int'(fv4), 1);
    check({tag, ".bottom"}, int'(hb8), int'(hits[0]));
    check({tag, ".top"},    int'(ht8), int'(hits[1]));
    check({tag, ".left"},   int'(hl8), int'(hits[2]));
    check({tag, ".right"},  int'(hr8), int'(hits[3]));
    check({tag, ".body"},   int'(ov8), int'(hits[4]));
    check({tag, ".cnt"},    int'(gc8), cnt);
    check({tag, ".cnt4"},   int'(gc4), (cnt > 15) ? 15 : cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, int'(fv8), 0);
    check({tag, ".valid4"}, int'(fv4), 0);
    check({tag, ".flags"}, int'({ov8, hr8, hl8, ht8, hb8}), 0);
    check({tag, ".cnt"}, int'(gc8), 0);
    check({tag, ".cnt4"}, int'(gc4), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{px: 100, py: 359, hits: 5'b00001, cnt: 64};
    vecs[1] = '{px: 26,  py: 200, hits: 5'b00100, cnt: 0};
    vecs[2] = '{px: 0,   py: 0,   hits: 5'b11001, cnt: 50};
    vecs[3] = '{px: 600, py: 200, hits: 5'b11011, cnt: 34};
    vecs[4] = '{px: 100, py: 423, hits: 5'b00001, cnt: 64};

    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      pos_x = 10'(vecs[i].px);
      pos_y = 10'(vecs[i].py);
      tick();
      if (i == 0) check_zero("first_tick");
      scan(vecs[i].px, vecs[i].py);
      tick();
      check_frame($sformatf("vec%0d", i), vecs[i].hits, vecs[i].cnt);
      idle(1);
      check($sformatf("vec%0d.pulse_end", i), int'(fv8), 0);
      check($sformatf("vec%0d.hold", i), int'(gc8), vecs[i].cnt);
    end

    // Position change mid-frame is ignored until the next tick
    pos_x = 10'd100;
    pos_y = 10'd359;
    tick();
    pos_y = 10'd200;
    scan(100, 359);
    tick();
    check_frame("midpos", 5'b00001, 64);
    scan(100, 200);
    tick();
    check_frame("midpos_next", 5'b00000, 0);

    // Pixel in flight at the tick counts; the pixel on the tick cycle is dropped
    pos_y = 10'd359;
    tick();
    idle(2);
    drive(100, 391, 1'b1, 1'b0);
    drive(100, 392, 1'b1, 1'b1);
    check_frame("inflight", 5'b00001, 1);
    idle(3);
    tick();
    check_frame("dropped", 5'b00000, 0);

    // Back-to-back ticks: second one latches an empty frame
    drive(100, 391, 1'b1, 1'b0);
    tick();
    check_frame("b2b_first", 5'b00001, 1);
    tick();
    check_frame("b2b_second", 5'b00000, 0);
    idle(1);
    check("b2b_pulse_end", int'(fv8), 0);

    // Mid-frame reset clears at once and re-arms
    drive(100, 391, 1'b1, 1'b0);
    tick();
    check_frame("pre_reset", 5'b00001, 1);
    drive(101, 391, 1'b1, 1'b0);
    drive(102, 391, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    tick();
    check_zero("rearm_tick");
    scan(100, 359);
    tick();
    check_frame("rearm_frame", 5'b00001, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wall_probe_collider.md
Name: wall_probe_collider

Overview:
- Consumes the per-pixel wall flag from the map stage during active scan and checks it against five rectangular probe windows around one player sprite.
- The windows are below the feet, above the head, left of the body, right of the body, and the body itself.
- Per-frame hit flags and a ground-contact pixel count are latched at each frame boundary. The player physics block uses them the next frame.
- Sits between the map/VGA pixel path and the player motion controller. One instance per character (Fireboy, Watergirl).

Parameters:
- PLAYER_W, 32, sprite width in pixels
- PLAYER_H, 32, sprite height in pixels
- PROBE, 2, probe strip thickness in pixels
- CNT_W, 8, width of ground-contact count (saturating)

Ports:
- Clk  in  1  pixel clock, shared with the VGA controller
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current scan X
- DrawY  in  10  current scan Y
- Blank_n  in  1  high during active video
- is_Wall  in  1  wall flag for (DrawX, DrawY) from the map stage, same-cycle combinational
- Frame_tick  in  1  one-cycle pulse at start of vertical blank
- PosX  in  10  player top-left X, may change at any time
- PosY  in  10  player top-left Y
- Hit_bottom  out  1  wall seen in the feet strip last frame
- Hit_top  out  1  wall seen in the head strip
- Hit_left  out  1  wall seen in the left strip
- Hit_right  out  1  wall seen in the right strip
- Overlap  out  1  wall seen inside the body
- Ground_cnt  out  CNT_W  count of wall pixels in the feet strip, saturating at 2^CNT_W-1
- Flags_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (async, Reset_n=0):
  - All outputs, accumulators, the snapshot position and the pipeline stage clear to 0.
  - The armed bit clears.
- Stage 1 (registered): captures DrawX, DrawY, Blank_n and is_Wall together each cycle.
- Stage 2: window compares use stage-1 coordinates against the snapshot position (SX, SY).
  - Compares use 11-bit signed arithmetic, so windows extending past X<0 or Y<0 are empty. There is no wrap.
  - Bottom window: X in [SX, SX+W), Y in [SY+H, SY+H+PROBE).
  - Top window: X in [SX, SX+W), Y in [SY-PROBE, SY).
  - Left window: X in [SX-PROBE, SX), Y in [SY, SY+H).
  - Right window: X in [SX+W, SX+W+PROBE), Y in [SY, SY+H).
  - Body window: X in [SX, SX+W), Y in [SY, SY+H).
- Accumulation: when stage-1 Blank_n=1 and is_Wall=1, each window that matches ORs into its sticky accumulator bit.
  - A bottom match also increments the ground accumulator, saturating.
  - Windows may overlap each other; each is evaluated independently.
- Frame_tick cycle:
  - Outputs load accumulator OR current stage-2 contribution. The pixel in flight is counted in the closing frame.
  - Accumulators clear.
  - The pixel presented on DrawX/DrawY during the tick cycle is dropped. It falls in blanking by construction.
  - SX/SY load PosX/PosY. PosX/PosY changes mid-frame are ignored until the next tick.
- Flags_valid:
  - Pulses one cycle after the tick, on the cycle the outputs are visible.
  - Suppressed for the first tick after reset; that tick only sets the armed bit and loads the snapshot.
  - Outputs stay 0 until the second tick.
- Outputs hold between ticks. Back-to-back ticks (adjacent cycles) are legal: the second tick latches an all-zero frame.
- Reset mid-frame: immediate clear; the partial frame is lost and the block re-arms as after power-up.
- Latency: pixel to accumulator is 2 cycles; tick to visible output is 1 cycle.

Decomposition:
- Package game_pkg:
  - H_ACTIVE=640 and V_ACTIVE=480.
  - A probe_e enum (BOTTOM, TOP, LEFT, RIGHT, BODY) used to index the 5-bit hit vector.
  - A signed 11-bit coord_t typedef.
- Sub-module probe_window_cmp:
  - Signed rectangle membership test with inputs x, y, x0, y0, and parameters w, h.
  - Instantiated 5 times.

Test Plan:
- Reset, then two ticks with PosX=100, PosY=359 and full-frame scan using the map's walls.
  - No Flags_valid on tick 1.
  - Tick 2 gives Hit_bottom=1 (platform at rows 391-392, X<215) and Ground_cnt=64; all other flags 0.
- PosX=26, PosY=200: left strip covers cols 24-25 and col 24 is wall, so Hit_left=1. Hit_right=0, Overlap=0, Ground_cnt=0.
- PosX=0, PosY=0: left and top windows are clipped empty, so Hit_left=0 and Hit_top=0. Overlap=1, since the body covers the wall at X<25 / Y<25.
- PosX=600, PosY=200: Overlap=1 and Hit_right=1 (X>=615 wall); Hit_left=0.
- Ground saturation: CNT_W=4 override, PosX=100, PosY=423 (bottom strip on the floor): Ground_cnt=15, Hit_bottom=1.
- PosY changes from 359 to 200 mid-frame: the frame still reports Hit_bottom=1 and Ground_cnt=64. The next frame reports Hit_bottom=0.
- Reset_n pulsed low mid-frame: outputs are 0 immediately, and there is no Flags_valid on the following tick.
